// File: rtl/pwr_seq_pkg.sv
// Shared types and helpers for the N-rail power sequencer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PG_WAIT = 3'd1,
    ST_ON_DLY  = 3'd2,
    ST_POR_DLY = 3'd3,
    ST_RUN     = 3'd4,
    ST_OFF_DLY = 3'd5,
    ST_FAULT   = 3'd6
  } pwr_state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_PG_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_PG_DROPOUT = 2'd2;

  // Widest configuration the extraction helper supports: 8 rails x 16-bit fields.
  localparam int unsigned MAX_DLY_W = 16;
  localparam int unsigned MAX_BUS_W = 128;

  // Pull field idx (w bits wide) out of a packed delay bus, zero-extended.
  function automatic logic [MAX_DLY_W-1:0] dly_field(input logic [MAX_BUS_W-1:0] bus,
                                                     input logic [2:0]           idx,
                                                     input int unsigned          w);
    logic [MAX_DLY_W-1:0] r;
    logic [6:0]           pos;
    r   = '0;
    pos = '0;
    for (int unsigned b = 0; b < MAX_DLY_W; b++) begin
      if (b < w) begin
        pos        = 7'(32'(idx) * w + b);
        r[4'(b)]   = bus[pos];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pwr_seq_ms_cnt.sv
// Millisecond tick counter shared by every timed state of the sequencer.
module pwr_seq_ms_cnt #(
  parameter int W = 11
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         clr,
  input  logic         ms_tick,
  input  logic [W-1:0] cmp,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count ticks since the last clear; saturate so a long stay never wraps back to a match.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ms_tick && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

  // A delay of 0 matches in the first cycle after the clear.
  assign done = (cnt == cmp);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// N-rail power sequencer: ordered power-up, reverse power-down, PG fault detection, POR release.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | all rails off, waiting for seq_en
// PG_WAIT    | rail idx enabled, waiting for its power-good (timeout guarded)
// ON_DLY     | rail idx good, waiting its post-PG delay
// POR_DLY    | all rails good, waiting before releasing por_n
// RUN        | fully powered, por_n released
// OFF_DLY    | rail idx disabled, waiting its off delay before the next one down
// FAULT      | all rails off, fault latched until seq_en drops
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int NUM_RAILS     = 4,
  parameter int DLY_W         = 11,
  parameter int PG_TIMEOUT_MS = 50,
  parameter int POR_DLY_MS    = 100
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       ms_tick,
  input  logic                       seq_en,
  input  logic [NUM_RAILS-1:0]       pwrgd,
  input  logic [NUM_RAILS*DLY_W-1:0] on_dly_ms,
  input  logic [NUM_RAILS*DLY_W-1:0] off_dly_ms,
  output logic [NUM_RAILS-1:0]       rail_en,
  output logic                       por_n,
  output logic                       all_pwrgd,
  output logic                       fault,
  output logic [2:0]                 fault_rail,
  output logic [1:0]                 fault_code,
  output logic                       busy
);

  localparam logic [2:0]       LAST_IDX = 3'(NUM_RAILS - 1);
  localparam logic [DLY_W-1:0] PG_TO    = DLY_W'(PG_TIMEOUT_MS);
  localparam logic [DLY_W-1:0] POR_DLY  = DLY_W'(POR_DLY_MS);

  pwr_state_t           state, state_nxt;
  logic [2:0]           idx, idx_nxt;
  logic [NUM_RAILS-1:0] rail_en_nxt;
  logic                 por_n_nxt, all_pwrgd_nxt, fault_nxt, busy_nxt;
  logic [2:0]           fault_rail_nxt;
  logic [1:0]           fault_code_nxt;

  logic                 cnt_clr, cnt_done;
  logic [DLY_W-1:0]     cnt_cmp, on_cur, off_cur;
  logic                 pg_cur, drop_any;
  logic [2:0]           drop_rail;

  function automatic logic [NUM_RAILS-1:0] rail_bit(input logic [2:0] i);
    return {{(NUM_RAILS-1){1'b0}}, 1'b1} << i;
  endfunction

  assign pg_cur  = |(pwrgd & rail_bit(idx));
  assign cnt_clr = (state_nxt != state) || (idx_nxt != idx);

  // Select the delay the shared counter is compared against in the current state.
  always_comb begin
    on_cur  = DLY_W'(dly_field(MAX_BUS_W'(on_dly_ms), idx, DLY_W));
    off_cur = DLY_W'(dly_field(MAX_BUS_W'(off_dly_ms), idx, DLY_W));
    unique case (state)
      ST_PG_WAIT: cnt_cmp = PG_TO;
      ST_ON_DLY:  cnt_cmp = on_cur;
      ST_POR_DLY: cnt_cmp = POR_DLY;
      ST_OFF_DLY: cnt_cmp = off_cur;
      default:    cnt_cmp = '0;
    endcase
  end

  pwr_seq_ms_cnt #(.W(DLY_W)) u_ms_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (cnt_clr),
    .ms_tick   (ms_tick),
    .cmp       (cnt_cmp),
    .done      (cnt_done)
  );

  // Find the lowest enabled, already-confirmed rail whose power-good has dropped.
  always_comb begin
    drop_any  = 1'b0;
    drop_rail = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (((3'(j) < idx) || ((3'(j) == idx) && (state != ST_PG_WAIT)))
          && rail_en[j] && !pwrgd[j]) begin
        drop_any  = 1'b1;
        drop_rail = 3'(j);
      end
    end
  end

  // Next-state and next-output logic; faults beat seq_en fall, which beats delay completion.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    rail_en_nxt    = rail_en;
    por_n_nxt      = por_n;
    all_pwrgd_nxt  = all_pwrgd;
    fault_nxt      = fault;
    fault_rail_nxt = fault_rail;
    fault_code_nxt = fault_code;

    unique case (state)
      ST_IDLE: begin
        if (seq_en) begin
          idx_nxt     = '0;
          rail_en_nxt = rail_bit(3'd0);
          state_nxt   = ST_PG_WAIT;
        end
      end

      ST_PG_WAIT, ST_ON_DLY, ST_POR_DLY, ST_RUN: begin
        if (drop_any || ((state == ST_PG_WAIT) && cnt_done && !pg_cur)) begin
          state_nxt      = ST_FAULT;
          rail_en_nxt    = '0;
          por_n_nxt      = 1'b0;
          all_pwrgd_nxt  = 1'b0;
          fault_nxt      = 1'b1;
          fault_rail_nxt = drop_any ? drop_rail : idx;
          fault_code_nxt = drop_any ? FC_PG_DROPOUT : FC_PG_TIMEOUT;
        end else if (!seq_en) begin
          idx_nxt       = (state == ST_RUN) ? LAST_IDX : idx;
          rail_en_nxt   = rail_en & ~rail_bit(idx_nxt);
          por_n_nxt     = 1'b0;
          all_pwrgd_nxt = 1'b0;
          state_nxt     = ST_OFF_DLY;
        end else begin
          unique case (state)
            ST_PG_WAIT: if (pg_cur) state_nxt = ST_ON_DLY;
            ST_ON_DLY: begin
              if (cnt_done) begin
                if (idx < LAST_IDX) begin
                  idx_nxt     = idx + 3'd1;
                  rail_en_nxt = rail_en | rail_bit(idx_nxt);
                  state_nxt   = ST_PG_WAIT;
                end else begin
                  state_nxt = ST_POR_DLY;
                end
              end
            end
            ST_POR_DLY: begin
              if (cnt_done) begin
                por_n_nxt     = 1'b1;
                all_pwrgd_nxt = 1'b1;
                state_nxt     = ST_RUN;
              end
            end
            default: ;
          endcase
        end
      end

      ST_OFF_DLY: begin
        // pwrgd is deliberately ignored here; rails are expected to collapse.
        if (cnt_done) begin
          if (idx == 3'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt     = idx - 3'd1;
            rail_en_nxt = rail_en & ~rail_bit(idx_nxt);
          end
        end
      end

      ST_FAULT: begin
        if (!seq_en) begin
          state_nxt      = ST_IDLE;
          idx_nxt        = '0;
          fault_nxt      = 1'b0;
          fault_rail_nxt = '0;
          fault_code_nxt = FC_NONE;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        idx_nxt     = '0;
        rail_en_nxt = '0;
        por_n_nxt   = 1'b0;
      end
    endcase

    busy_nxt = !(state_nxt inside {ST_IDLE, ST_RUN, ST_FAULT});
  end

  // State, index and all outputs are registered.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      rail_en    <= '0;
      por_n      <= 1'b0;
      all_pwrgd  <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
      fault_code <= FC_NONE;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rail_en    <= rail_en_nxt;
      por_n      <= por_n_nxt;
      all_pwrgd  <= all_pwrgd_nxt;
      fault      <= fault_nxt;
      fault_rail <= fault_rail_nxt;
      fault_code <= fault_code_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
